izh_spike_decoder: RTL and testbench



---
 rtl/izh_spike_decoder.sv | 172 +++++++++++++++++
 tb/tb_izh_spike_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_spike_decoder.sv
// izh_spike_decoder
//   Receive-side decoder for the neuron membrane-voltage stream. It detects
//   spikes by threshold crossing with hysteresis, measures inter-spike
//   intervals (ISI) in accepted samples, and queues them in a show-ahead FIFO
//   that is drained through a valid/ready handshake.
//
//   Optional build macro: IZH_RATE_WINDOW_EN
//     When defined, this adds parameter WIN_LOG and output rate[7:0]. rate
//     holds the spike count of the last completed window of 2^WIN_LOG
//     accepted samples.
//
//   Ports
//     clk, rst      clock, asynchronous active-high reset
//     v_in          signed membrane voltage sample (VW bits)
//     v_valid       sample strobe
//     en            decoder enable; when low, all state holds
//     spike         one-cycle pulse per detected spike
//     isi_data      FIFO head ISI (0 when empty)
//     isi_valid     FIFO not empty
//     isi_ready     consumer pop
//     spike_count   spikes since reset; wraps at 16 bits
//     ovf           sticky: ISI dropped because the FIFO was full
//     ovf_clr       clears ovf; a same-cycle overflow takes priority
//     rate          (IZH_RATE_WINDOW_EN only) spikes in the last window
module izh_spike_decoder #(
  parameter int VW        = 8,
  parameter int ISI_W     = 16,
  parameter int DEPTH_LOG = 2,
  parameter int TH_HI     = 16,
  parameter int TH_LO     = -16
`ifdef IZH_RATE_WINDOW_EN
  ,parameter int WIN_LOG  = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [VW-1:0] v_in,
  input  logic                 v_valid,
  input  logic                 en,
  output logic                 spike,
  output logic [ISI_W-1:0]     isi_data,
  output logic                 isi_valid,
  input  logic                 isi_ready,
  output logic [15:0]          spike_count,
  output logic                 ovf,
  input  logic                 ovf_clr
`ifdef IZH_RATE_WINDOW_EN
  ,output logic [7:0]          rate
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]     FULL_CNT = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [ISI_W-1:0]       ISI_MAX  = '1;
  localparam logic signed [VW-1:0]   HI       = VW'(TH_HI);
  localparam logic signed [VW-1:0]   LO       = VW'(TH_LO);

  typedef enum logic [1:0] {
    S_INIT,
    S_ARMED,
    S_REFRAC
  } state_t;

  state_t           state;
  logic [ISI_W-1:0] isi_cnt;
  logic             first_spike;

  logic             accept;
  logic             spike_evt;
  logic [ISI_W-1:0] isi_rec;
  logic             push;
  logic             pop;
  logic             full;
  logic             push_ok;

  logic [ISI_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;

  assign accept    = en && v_valid;
  assign spike_evt = accept && (state == S_ARMED) && (v_in >= HI);
  assign isi_rec   = (isi_cnt == ISI_MAX) ? ISI_MAX : isi_cnt + ISI_W'(1);

  // The very first spike after reset has no preceding spike, so no interval.
  assign push      = spike_evt && !first_spike;
  assign isi_valid = (count != '0);
  assign pop       = isi_valid && isi_ready;
  assign full      = (count == FULL_CNT);
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_ok   = push && (!full || pop);
  assign isi_data  = isi_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      isi_cnt     <= '0;
      first_spike <= 1'b1;
      spike       <= 1'b0;
      spike_count <= '0;
      ovf         <= 1'b0;
    end else begin
      spike <= 1'b0;
      if (accept) begin
        case (state)
          S_INIT:   if (v_in <= LO) state <= S_ARMED;
          S_ARMED:  if (v_in >= HI) state <= S_REFRAC;
          S_REFRAC: if (v_in <= LO) state <= S_ARMED;
          default:  state <= S_INIT;
        endcase
        if (spike_evt) begin
          spike       <= 1'b1;
          spike_count <= spike_count + 16'd1;
          isi_cnt     <= '0;
          first_spike <= 1'b0;
        end else if (isi_cnt != ISI_MAX) begin
          isi_cnt <= isi_cnt + ISI_W'(1);
        end
      end
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: isi_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= isi_rec;
  end

`ifdef IZH_RATE_WINDOW_EN
  logic [WIN_LOG-1:0] win_pos;
  logic [7:0]         win_spk;

  // rate loads the count accumulated before the final window sample; a spike
  // on that final sample seeds the next window instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_pos <= '0;
      win_spk <= '0;
      rate    <= '0;
    end else if (accept) begin
      win_pos <= win_pos + 1'b1;
      if (&win_pos) begin
        rate    <= win_spk;
        win_spk <= spike_evt ? 8'd1 : 8'd0;
      end else if (spike_evt && (win_spk != 8'hFF)) begin
        win_spk <= win_spk + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_izh_spike_decoder.sv
module tb_izh_spike_decoder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] v_in = '0;
  logic              v_valid = 1'b0;
  logic              en = 1'b0;
  logic              isi_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              spike;
  logic [15:0]       isi_data;
  logic              isi_valid;
  logic [15:0]       spike_count;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef IZH_RATE_WINDOW_EN
  logic [7:0] rate;
  izh_spike_decoder #(.WIN_LOG(4)) dut (
    .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid), .en(en),
    .spike(spike), .isi_data(isi_data), .isi_valid(isi_valid),
    .isi_ready(isi_ready), .spike_count(spike_count), .ovf(ovf),
    .ovf_clr(ovf_clr), .rate(rate)
  );
`else
  izh_spike_decoder dut (
    .clk(clk), .rst(rst), .v_in(v_in), .v_valid(v_valid), .en(en),
    .spike(spike), .isi_data(isi_data), .isi_valid(isi_valid),
    .isi_ready(isi_ready), .spike_count(spike_count), .ovf(ovf),
    .ovf_clr(ovf_clr)
  );
`endif

  typedef struct {
    bit rs;
    bit vv;
    bit en;
    bit rdy;
    int v;
    bit exp_spike;
    int exp_cnt;
    bit exp_valid;
    bit push;
    int pv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle; if a pop will happen at the coming edge, the FIFO head
  // is compared against the scoreboard first.
  task automatic cyc(input int v, input bit vv, input bit e, input bit rdy, input bit clr);
    v_in      = 8'(v);
    v_valid   = vv;
    en        = e;
    isi_ready = rdy;
    ovf_clr   = clr;
    if (isi_valid && rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: DUT offered %0d with no expected entry", isi_data);
      end else begin
        chk("isi_pop", isi_data, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v_valid   = 1'b0;
    en        = 1'b0;
    isi_ready = 1'b0;
    ovf_clr   = 1'b0;
    v_in      = '0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[28];
    //          rs vv en rdy  v   spk cnt val push pv
    tbl[0]  = '{1, 1, 1, 0, -45, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0,  19, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0, -32, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 0, -45, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0,  19, 1, 2, 1, 1, 3};
    tbl[5]  = '{0, 0, 1, 1,   0, 0, 2, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 0,  25, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0,  25, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0,  25, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0,  25, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0,  25, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 0, -45, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 0,  20, 1, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 1, 0, -45, 0, 1, 0, 0, 0};
    tbl[14] = '{0, 1, 1, 0,  19, 1, 2, 1, 1, 2};
    tbl[15] = '{0, 1, 1, 0,  10, 0, 2, 1, 0, 0};
    tbl[16] = '{0, 1, 1, 0,  22, 0, 2, 1, 0, 0};
    tbl[17] = '{0, 1, 1, 0, -20, 0, 2, 1, 0, 0};
    tbl[18] = '{0, 0, 1, 1,   0, 0, 2, 0, 0, 0};
    tbl[19] = '{0, 1, 0, 0,  19, 0, 2, 0, 0, 0};
    tbl[20] = '{0, 1, 1, 0,  19, 1, 3, 1, 1, 4};
    tbl[21] = '{0, 0, 1, 1,   0, 0, 3, 0, 0, 0};
    tbl[22] = '{0, 1, 1, 0, -16, 0, 3, 0, 0, 0};
    tbl[23] = '{0, 1, 1, 0,  15, 0, 3, 0, 0, 0};
    tbl[24] = '{0, 1, 1, 0,  16, 1, 4, 1, 1, 3};
    tbl[25] = '{0, 1, 1, 0, -15, 0, 4, 1, 0, 0};
    tbl[26] = '{0, 1, 1, 0,  16, 0, 4, 1, 0, 0};
    tbl[27] = '{0, 0, 1, 1,   0, 0, 4, 0, 0, 0};

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_spike", spike, 0);
    chk("rst_isi_valid", isi_valid, 0);
    chk("rst_isi_data", isi_data, 0);
    chk("rst_spike_count", spike_count, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    // Table-driven: basic detection, start-above-threshold, ringing,
    // single-cycle enable gap, exact threshold boundaries.
    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      if (tbl[i].push) exp_q.push_back(16'(tbl[i].pv));
      cyc(tbl[i].v, tbl[i].vv, tbl[i].en, tbl[i].rdy, 1'b0);
      chk($sformatf("v%0d_spike", i), spike, 32'(tbl[i].exp_spike));
      chk($sformatf("v%0d_count", i), spike_count, 32'(tbl[i].exp_cnt));
      chk($sformatf("v%0d_isi_valid", i), isi_valid, 32'(tbl[i].exp_valid));
    end
    chk("tbl_sb_empty", 32'(exp_q.size()), 0);

    // Overflow, set-wins over clear, push+pop while full
    do_reset();
    cyc(-45, 1, 1, 0, 0);
    cyc(19, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(-45, 1, 1, 0, 0);
      cyc(-45, 1, 1, 0, 0);
      cyc(-45, 1, 1, 0, 0);
      if (k < 4) exp_q.push_back(16'd4);
      cyc(19, 1, 1, 0, 0);
    end
    chk("ovf_set", ovf, 1);
    chk("ovf_isi_valid", isi_valid, 1);
    chk("ovf_spike_count", spike_count, 6);
    cyc(0, 0, 1, 0, 1);
    chk("ovf_clr", ovf, 0);
    cyc(-45, 1, 1, 0, 0);
    cyc(-45, 1, 1, 0, 0);
    cyc(-45, 1, 1, 0, 0);
    cyc(19, 1, 1, 0, 1);
    chk("ovf_set_wins", ovf, 1);
    cyc(0, 0, 1, 0, 1);
    chk("ovf_clr2", ovf, 0);
    cyc(-45, 1, 1, 0, 0);
    exp_q.push_back(16'd2);
    cyc(19, 1, 1, 1, 0);
    chk("pushpop_ovf", ovf, 0);
    chk("pushpop_valid", isi_valid, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 1, 0);
    chk("drain_valid", isi_valid, 0);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);

    // ISI saturation across a 70000-sample gap
    do_reset();
    cyc(-45, 1, 1, 0, 0);
    cyc(19, 1, 1, 0, 0);
    cyc(-45, 1, 1, 0, 0);
    for (int k = 0; k < 69999; k++) cyc(0, 1, 1, 0, 0);
    exp_q.push_back(16'hFFFF);
    cyc(19, 1, 1, 0, 0);
    chk("sat_spike", spike, 1);
    cyc(0, 0, 1, 1, 0);
    chk("sat_sb_empty", 32'(exp_q.size()), 0);

    // Enable low for 10 cycles mid-interval
    do_reset();
    cyc(-45, 1, 1, 0, 0);
    cyc(19, 1, 1, 0, 0);
    cyc(-45, 1, 1, 0, 0);
    cyc(-45, 1, 1, 0, 0);
    for (int k = 0; k < 10; k++) cyc(19, 1, 0, 0, 0);
    chk("en_low_no_spike", spike, 0);
    chk("en_low_count", spike_count, 1);
    cyc(-45, 1, 1, 0, 0);
    exp_q.push_back(16'd4);
    cyc(19, 1, 1, 0, 0);
    chk("en_resume_spike", spike, 1);
    cyc(0, 0, 1, 1, 0);
    chk("en_sb_empty", 32'(exp_q.size()), 0);

`ifdef IZH_RATE_WINDOW_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(-45, 1, 1, 0, 0);
      cyc(19, 1, 1, 0, 0);
    end
    for (int k = 0; k < 9; k++) cyc(-45, 1, 1, 0, 0);
    chk("rate_before_end", rate, 0);
    cyc(-45, 1, 1, 0, 0);
    chk("rate_window", rate, 3);
`endif

    // Asynchronous reset mid-stream with a full FIFO and a live spike pulse
    do_reset();
    cyc(-45, 1, 1, 0, 0);
    cyc(19, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(-45, 1, 1, 0, 0);
      cyc(19, 1, 1, 0, 0);
    end
    chk("pre_rst_spike", spike, 1);
    chk("pre_rst_ovf", ovf, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_spike", spike, 0);
    chk("arst_isi_valid", isi_valid, 0);
    chk("arst_isi_data", isi_data, 0);
    chk("arst_spike_count", spike_count, 0);
    chk("arst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
